muldiv_hilo: RTL
================

# muldiv_hilo

Iterative multiply/divide unit with architectural HI/LO registers in the execute stage, beside the combinational ALU. It takes the same operand pair the ALU receives, computes 64-bit products or quotient/remainder pairs over 33 cycles, and holds the results in HI/LO for move-from-HI/LO reads. It raises `busy` so the pipeline control can stall dependent instructions, and it accepts a flush that abandons an in-flight operation.

## Interface
- `WIDTH`, 32: operand width. Only 32 is supported; the iteration count equals `WIDTH`.
- `clk`  in  1  sole clock, rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request. Sampled only when `busy`=0.
- `op`  in  3  0 none, 1 mult (signed), 2 div (signed), 3 multu, 4 divu, 5 mthi, 6 mtlo, 7 none.
- `x`  in  32  multiplicand / dividend / mthi-mtlo source.
- `y`  in  32  multiplier / divisor.
- `flush`  in  1  synchronous abort of the in-flight operation.
- `busy`  out  1  an operation is in flight.
- `done`  out  1  one-cycle pulse: HI/LO were just written by mult/div.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- Reset values: `busy`=0, `done`=0, `hi`=0, `lo`=0, state IDLE, all internal accumulators 0.
- States: IDLE, RUN, FIX.
  - IDLE: on `start` with op 1–4, latch operand magnitudes and result signs, clear the counter, and go to RUN.
  - RUN: 32 iterations, one bit per cycle, counter 0..31. At 31, go to FIX.
  - FIX: apply the sign fix-up, write HI/LO, pulse `done`, and return to IDLE.
- Multiply: shift-add on magnitudes, 64-bit accumulator.
  - Signed product is negated when `x[31]^y[31]`.
  - `hi`=product[63:32], `lo`=product[31:0].
- Divide: restoring radix-2 on magnitudes.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - `lo`=quotient, `hi`=remainder.
  - Signed 0x8000_0000 / 0xFFFF_FFFF gives `lo`=0x8000_0000, `hi`=0.
- Divide by zero: no trap. `lo`=0xFFFF_FFFF, `hi`=`x`, with normal latency.
- mthi/mtlo: accepted in IDLE only. Write `hi` (or `lo`) with `x` on the accepting edge. No `busy`, no `done`.
- Op 0/7 with `start`: ignored.
- `start` while `busy`=1: ignored entirely. Upstream must hold the request until `busy`=0.
- `flush`:
  - In RUN or FIX: go to IDLE on that edge with `busy`=0, HI/LO unchanged, no `done`.
  - In IDLE: `flush` overrides a simultaneous `start`, so nothing is accepted.
- Reset mid-operation: all state returns immediately (asynchronously) to reset values. The partial result is discarded.

## Timing
- Edge E0 accepts mult/div. `busy`=1 from after E0 until after E33.
- E1..E32 run the iterations. E33 (FIX) writes `hi`/`lo`.
- `busy`=0 and `done`=1 in the cycle after E33. Latency is 33 cycles, start to result-visible.
- The earliest next accept is E34, in the `done` cycle.
- `hi`/`lo` are registered outputs. Reads see the value written on the preceding edge, with no bypass.
- mthi/mtlo have 1-cycle latency. A back-to-back mthi then mult on consecutive cycles is legal.

## Configuration
- `MULDIV_UNSIGNED_EN` defined:
  - ops 3 (multu) and 4 (divu) are implemented.
  - Operands are treated as unsigned with no sign fix-up.
  - divu by zero gives `lo`=0xFFFF_FFFF, `hi`=`x`.
- `MULDIV_UNSIGNED_EN` undefined:
  - ops 3 and 4 behave as op 0. They are ignored: no `busy`, HI/LO unchanged.
  - The unsigned path logic is removed.

## Test plan
- Signed mult: `x`=0xFFFF_FFFE (−2), `y`=3. Required: `done` 33 cycles after accept, `hi`=0xFFFF_FFFF, `lo`=0xFFFF_FFFA.
- Signed div: `x`=−7, `y`=2. Required: `lo`=0xFFFF_FFFD (−3), `hi`=0xFFFF_FFFF (−1). Edge case 0x8000_0000 / −1 gives `lo`=0x8000_0000, `hi`=0.
- Divide by zero: `x`=0x1234_5678, `y`=0. Required: `lo`=0xFFFF_FFFF, `hi`=0x1234_5678, `busy` held for 33 cycles.
- Flush: assert `flush` 10 cycles into a mult following mthi 0xAAAA_AAAA. Required: `busy` drops next cycle, no `done`, `hi`=0xAAAA_AAAA. A second `start` during `busy` leaves the result unaffected.
- Reset: drop `rst_n` mid-divide. Required: `busy`, `done`, `hi`, `lo` read 0 immediately, without waiting for a clock edge.
- With `MULDIV_UNSIGNED_EN`: multu 0xFFFF_FFFF × 0xFFFF_FFFF gives `hi`=0xFFFF_FFFE, `lo`=1. Without the macro, the same request leaves `busy`=0 and HI/LO unchanged.

Source files
------------

// File: rtl/muldiv_hilo.sv
// rtl/muldiv_hilo.sv - iterative 32-cycle multiply/divide unit with HI/LO registers
// Optional unsigned multu/divu path enabled by defining MULDIV_UNSIGNED_EN.
module muldiv_hilo #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             flush,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int W   = WIDTH;
  localparam int CW  = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state, state_next;
  logic [CW-1:0]  cnt;
  logic [2*W-1:0] acc;
  logic [W-1:0]   opnd;
  logic           is_div, div0, neg_q, neg_r;

  logic           md_op, div_op, sgn_op, accept, idle_req;
  logic [W-1:0]   x_mag, y_mag;
  logic [W:0]     mul_sum, div_trial;
  logic [W-1:0]   div_diff;
  logic           div_ge;
  logic [2*W-1:0] mul_next, div_next, prod;
  logic [W-1:0]   quo, rem, fix_hi, fix_lo;

  always_comb begin
    md_op  = 1'b0;
    div_op = 1'b0;
    sgn_op = 1'b0;
    case (op)
      3'd1: begin md_op = 1'b1; sgn_op = 1'b1; end
      3'd2: begin md_op = 1'b1; div_op = 1'b1; sgn_op = 1'b1; end
`ifdef MULDIV_UNSIGNED_EN
      3'd3: md_op = 1'b1;
      3'd4: begin md_op = 1'b1; div_op = 1'b1; end
`endif
      default: ;
    endcase
  end

  assign idle_req = start && !flush && (state == IDLE);
  assign accept   = idle_req && md_op;
  assign x_mag    = (sgn_op && x[W-1]) ? -x : x;
  assign y_mag    = (sgn_op && y[W-1]) ? -y : y;

  // Multiply: right-shift shift-add, multiplier starts in acc low half.
  assign mul_sum  = {1'b0, acc[2*W-1:W]} + (acc[0] ? {1'b0, opnd} : '0);
  assign mul_next = {mul_sum, acc[W-1:1]};

  // Divide: restoring, remainder in acc high half, dividend/quotient in low half.
  assign div_trial = acc[2*W-1:W-1];
  assign div_ge    = div_trial >= {1'b0, opnd};
  assign div_diff  = div_trial[W-1:0] - opnd;
  assign div_next  = {div_ge ? div_diff : div_trial[W-1:0], acc[W-2:0], div_ge};

  assign prod   = neg_q ? -acc : acc;
  assign quo    = div0 ? '1 : (neg_q ? -acc[W-1:0] : acc[W-1:0]);
  assign rem    = neg_r ? -acc[2*W-1:W] : acc[2*W-1:W];
  assign fix_hi = is_div ? rem : prod[2*W-1:W];
  assign fix_lo = is_div ? quo : prod[W-1:0];

  assign busy = (state != IDLE);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (accept) state_next = RUN;
      RUN:  if (flush) state_next = IDLE;
            else if (cnt == CW'(W-1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      div0   <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= (state == FIX) && !flush;
      if (accept) begin
        cnt    <= '0;
        is_div <= div_op;
        div0   <= (y == '0);
        neg_q  <= sgn_op && (x[W-1] ^ y[W-1]);
        neg_r  <= sgn_op && x[W-1];
        acc    <= {{W{1'b0}}, div_op ? x_mag : y_mag};
        opnd   <= div_op ? y_mag : x_mag;
      end else if (state == RUN && !flush) begin
        cnt <= cnt + 1'b1;
        acc <= is_div ? div_next : mul_next;
      end
      if (state == FIX && !flush) begin
        hi <= fix_hi;
        lo <= fix_lo;
      end
      if (idle_req && op == 3'd5) hi <= x;
      if (idle_req && op == 3'd6) lo <= x;
    end
  end

endmodule
